// File: rtl/iref_dac_pkg.sv
// Shared FSM state encoding and default sizing for the current-reference DAC driver.
package iref_dac_pkg;

  localparam int DEF_BUS_WIDTH = 10;
  localparam int DEF_MAX_STEP  = 16;
  localparam int DEF_SCLK_DIV  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STEP  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

endpackage

// File: rtl/dac_spi_tx.sv
// Serializer for one DAC word: MSB first, SCLK_DIV clk cycles per sclk half-period.
module dac_spi_tx
  import iref_dac_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int SCLK_DIV  = DEF_SCLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] data,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 done
);

  localparam int DIV_W = $clog2(SCLK_DIV + 1);
  localparam int BIT_W = $clog2(BUS_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(BUS_WIDTH - 1);

  logic [BUS_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 phase_q, phase_d;
  logic                 active_q, active_d;
  logic                 div_tc, bit_tc;

  assign div_tc = (div_cnt_q == '0);
  assign bit_tc = (bit_cnt_q == '0);

  always_comb begin
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    phase_d   = phase_q;
    active_d  = active_q;
    done      = 1'b0;
    if (start) begin
      shreg_d   = data;
      div_cnt_d = DIV_LOAD;
      bit_cnt_d = BIT_LOAD;
      phase_d   = 1'b0;
      active_d  = 1'b1;
    end else if (active_q) begin
      if (div_tc) begin
        div_cnt_d = DIV_LOAD;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // data advances only on the high->low sclk transition
          phase_d = 1'b0;
          if (bit_tc) begin
            active_d = 1'b0;
            done     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            shreg_d   = shreg_q << 1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      phase_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
    end
  end

  assign sclk  = phase_q;
  assign sdata = shreg_q[BUS_WIDTH-1];

endmodule

// File: rtl/iref_dac_driver.sv
// Slew-limited current-reference DAC driver: steps the applied code toward the target,
// at most MAX_STEP per serial frame.
//   state | meaning
//   IDLE  | applied code matches target (or enable low); bus quiet
//   STEP  | one cycle: compute clamped next code, cs_n low, MSB on sdata
//   SHIFT | serializer clocks out BUS_WIDTH bits
//   LATCH | one cycle: cs_n high latches DAC, applied code updated
module iref_dac_driver
  import iref_dac_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int MAX_STEP  = DEF_MAX_STEP,
  parameter int SCLK_DIV  = DEF_SCLK_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [BUS_WIDTH-1:0] i_ref,
  input  logic                 i_ref_valid,
  output logic                 i_ref_ready,
  output logic                 dac_sclk,
  output logic                 dac_sdata,
  output logic                 dac_cs_n,
  output logic [BUS_WIDTH-1:0] i_ref_applied,
  output logic                 busy
);

  localparam int SW = BUS_WIDTH + 1;
  localparam logic signed [SW-1:0] STEP_MAX = SW'(MAX_STEP);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] target_q, target_d;
  logic [BUS_WIDTH-1:0] applied_q, applied_d;
  logic [BUS_WIDTH-1:0] next_q, next_d;
  logic signed [SW-1:0] delta, delta_clamped, sum;
  logic [BUS_WIDTH-1:0] step_code;
  logic                 want_frame, tx_start, tx_done, tx_sclk, tx_sdata;

  // One extra sign bit keeps the difference and the sum exact across the full code range.
  always_comb begin
    delta = $signed({1'b0, target_q}) - $signed({1'b0, applied_q});
    if (delta > STEP_MAX)       delta_clamped = STEP_MAX;
    else if (delta < -STEP_MAX) delta_clamped = -STEP_MAX;
    else                        delta_clamped = delta;
    sum       = $signed({1'b0, applied_q}) + delta_clamped;
    step_code = sum[BUS_WIDTH] ? '0 : sum[BUS_WIDTH-1:0];
  end

  assign want_frame = enable && (target_q != applied_q);

  always_comb begin
    state_d   = state_q;
    target_d  = i_ref_valid ? i_ref : target_q;
    applied_d = applied_q;
    next_d    = next_q;
    tx_start  = 1'b0;
    case (state_q)
      IDLE:  if (want_frame) state_d = STEP;
      STEP: begin
        tx_start = 1'b1;
        next_d   = step_code;
        state_d  = SHIFT;
      end
      SHIFT: if (tx_done) begin
        applied_d = next_q;
        state_d   = LATCH;
      end
      LATCH: state_d = want_frame ? STEP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      target_q  <= '0;
      applied_q <= '0;
      next_q    <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      next_q    <= next_d;
    end
  end

  dac_spi_tx #(
    .BUS_WIDTH (BUS_WIDTH),
    .SCLK_DIV  (SCLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .start (tx_start),
    .data  (step_code),
    .sclk  (tx_sclk),
    .sdata (tx_sdata),
    .done  (tx_done)
  );

  assign i_ref_ready   = 1'b1;
  assign i_ref_applied = applied_q;
  assign busy          = (state_q != IDLE);
  assign dac_cs_n      = !((state_q == STEP) || (state_q == SHIFT));
  assign dac_sclk      = (state_q == SHIFT) && tx_sclk;
  assign dac_sdata     = (state_q == STEP)  ? step_code[BUS_WIDTH-1] :
                         (state_q == SHIFT) ? tx_sdata : 1'b0;

endmodule

// File: tb/tb_iref_dac_driver.sv
// Directed bench for iref_dac_driver: target-sweep table plus retarget, enable and reset sequences.
module tb_iref_dac_driver;

  localparam int BW        = 10;
  localparam int FRAME_LEN = 2 + 2 * 2 * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [BW-1:0] i_ref = '0;
  logic          i_ref_valid = 1'b0;
  logic          i_ref_ready, dac_sclk, dac_sdata, dac_cs_n, busy;
  logic [BW-1:0] i_ref_applied;

  int checks = 0;
  int errors = 0;

  iref_dac_driver dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .i_ref         (i_ref),
    .i_ref_valid   (i_ref_valid),
    .i_ref_ready   (i_ref_ready),
    .dac_sclk      (dac_sclk),
    .dac_sdata     (dac_sdata),
    .dac_cs_n      (dac_cs_n),
    .i_ref_applied (i_ref_applied),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Serial-bus monitor: collects each completed frame word
  logic [BW-1:0] sh_word = '0;
  int  sclk_edges = 0;
  int  cs_low_cycles = 0;
  bit  mon_en = 1'b0;
  int  frames[$];

  always @(negedge dac_cs_n) begin
    sclk_edges    = 0;
    sh_word       = '0;
    cs_low_cycles = 0;
  end

  always @(posedge dac_sclk) begin
    if (!dac_cs_n) begin
      sh_word = {sh_word[BW-2:0], dac_sdata};
      sclk_edges++;
    end
  end

  always @(negedge clk) if (!dac_cs_n) cs_low_cycles++;

  always @(posedge dac_cs_n) begin
    if (rst && mon_en) begin
      #1;
      chk("frame_sclk_edges", sclk_edges, BW);
      chk("frame_cs_low_cycles", cs_low_cycles, FRAME_LEN - 1);
      chk("frame_word_vs_applied", int'(sh_word), int'(i_ref_applied));
      frames.push_back(int'(sh_word));
    end
  end

  task automatic drive_target(input int t);
    @(negedge clk);
    i_ref       = BW'(t);
    i_ref_valid = 1'b1;
    @(negedge clk);
    i_ref_valid = 1'b0;
  endtask

  task automatic wait_cs_low(input string nm);
    int c = 0;
    while (dac_cs_n && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (dac_cs_n) timeout(nm);
  endtask

  task automatic wait_idle(input string nm, output int bc);
    int c = 0;
    bc = 0;
    while (c < 6000) begin
      if (busy) bc++;
      else if (c >= 3) break;
      @(negedge clk);
      c++;
    end
    if (busy) timeout(nm);
  endtask

  task automatic run_target(input string nm, input int tgt, input int n,
                            input int f0, input int f1, input int fl);
    int bc;
    frames.delete();
    drive_target(tgt);
    wait_idle(nm, bc);
    chk({nm, "_nframes"}, frames.size(), n);
    chk({nm, "_busy_cycles"}, bc, n * FRAME_LEN);
    chk({nm, "_applied"}, int'(i_ref_applied), tgt);
    if (n > 0 && frames.size() > 0) begin
      chk({nm, "_first"}, frames[0], f0);
      chk({nm, "_last"}, frames[frames.size()-1], fl);
    end
    if (n > 1 && frames.size() > 1) chk({nm, "_second"}, frames[1], f1);
  endtask

  typedef struct {
    string name;
    int    target;
    int    n;
    int    f0;
    int    f1;
    int    fl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bc;

    vecs[0] = '{"ramp_up_40",     40,   3,  16,   32,   40};
    vecs[1] = '{"ramp_down_0",     0,   3,  24,    8,    0};
    vecs[2] = '{"no_change",       0,   0,   0,    0,    0};
    vecs[3] = '{"ramp_to_1020", 1020,  64,  16,   32, 1020};
    vecs[4] = '{"small_1023",   1023,   1, 1023, 1023, 1023};
    vecs[5] = '{"down_1000",    1000,   2, 1007, 1000, 1000};
    vecs[6] = '{"small_1005",   1005,   1, 1005, 1005, 1005};
    vecs[7] = '{"long_down_0",     0,  63,  989,  973,    0};

    repeat (3) @(negedge clk);
    chk("rst_cs_n", int'(dac_cs_n), 1);
    chk("rst_sclk", int'(dac_sclk), 0);
    chk("rst_sdata", int'(dac_sdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_applied", int'(i_ref_applied), 0);
    chk("ready", int'(i_ref_ready), 1);

    rst    = 1'b1;
    enable = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_target(vecs[i].name, vecs[i].target, vecs[i].n, vecs[i].f0, vecs[i].f1, vecs[i].fl);

    // Retarget while frame 1 is shifting: frame in flight unchanged, next uses new target
    frames.delete();
    drive_target(100);
    wait_cs_low("retarget_start");
    repeat (10) @(negedge clk);
    drive_target(20);
    wait_idle("retarget_idle", bc);
    chk("retarget_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("retarget_f0", frames[0], 16);
      chk("retarget_f1", frames[1], 20);
    end
    chk("retarget_applied", int'(i_ref_applied), 20);

    run_target("back_to_0", 0, 2, 4, 0, 0);

    // Enable dropped mid-frame: frame completes, nothing follows until re-enabled
    frames.delete();
    drive_target(100);
    wait_cs_low("gate_start");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle("gate_idle", bc);
    repeat (100) @(negedge clk);
    chk("gate_busy_held_low", int'(busy), 0);
    chk("gate_nframes", frames.size(), 1);
    if (frames.size() > 0) chk("gate_f0", frames[0], 16);
    chk("gate_applied", int'(i_ref_applied), 16);
    frames.delete();
    enable = 1'b1;
    wait_cs_low("regate_start");
    wait_idle("regate_idle", bc);
    chk("regate_nframes", frames.size(), 6);
    if (frames.size() > 0) chk("regate_f0", frames[0], 32);
    chk("regate_applied", int'(i_ref_applied), 100);

    // Asynchronous reset while sclk is high in mid-frame
    frames.delete();
    drive_target(0);
    wait_cs_low("reset_frame_start");
    @(posedge dac_sclk);
    #1 rst = 1'b0;
    #1;
    chk("arst_cs_n", int'(dac_cs_n), 1);
    chk("arst_sclk", int'(dac_sclk), 0);
    chk("arst_sdata", int'(dac_sdata), 0);
    chk("arst_applied", int'(i_ref_applied), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("post_rst_busy_cycles", bc, 0);
    chk("post_rst_nframes", frames.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
